ldl_round_dispatch: RTL and testbench

LDL_ROUND_DISPATCH -- requirements
Module: LDL_round_dispatch

---
 rtl/ldl_round_dispatch.sv | 105 ++++++++++
 tb/tb_ldl_round_dispatch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ldl_round_dispatch.sv
// ldl_round_dispatch: distributes one upstream stream over CH_NUM output channels.
// Each channel has a one-entry buffer. Channels are chosen round robin, starting
// after the channel loaded last (pre_bin).
// Optional build feature: define LDL_ROUND_DISPATCH_CNT_EN to add a saturating
// 16-bit load counter per channel on cnt. Without the macro, cnt is tied to zero.
//
// Handshake (both sides): a word moves when valid and ready are high together at
// a rising edge. valid never depends on ready. A producer holds its word stable
// until the transfer happens. s_ready is combinational from the buffer flags and
// m_ready only. It never depends on s_valid.
module ldl_round_dispatch #(
  parameter int BIN_WIDTH  = 3,
  parameter int CH_NUM     = 1 << BIN_WIDTH,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic [CH_NUM-1:0]            m_valid,
  input  logic [CH_NUM-1:0]            m_ready,
  output logic [CH_NUM*DATA_WIDTH-1:0] m_data,
  output logic [BIN_WIDTH-1:0]         pre_bin,
  output logic [CH_NUM*16-1:0]         cnt
);

  logic [CH_NUM-1:0]     full;
  logic [DATA_WIDTH-1:0] data_q [CH_NUM];
  logic [CH_NUM-1:0]     free;
  logic [BIN_WIDTH-1:0]  sel;
  logic [BIN_WIDTH-1:0]  idx;
  logic                  found;
  logic                  load;

  // A buffer that drains this cycle can take a new word in the same cycle.
  assign free    = ~full | m_ready;
  assign s_ready = |free;
  assign load    = s_valid & s_ready;
  assign m_valid = full;

  // Round-robin search. It starts at pre_bin+1 and wraps. pre_bin itself is checked last.
  always_comb begin
    sel   = pre_bin;
    idx   = pre_bin;
    found = 1'b0;
    for (int k = 1; k <= CH_NUM; k++) begin
      idx = pre_bin + BIN_WIDTH'(k);
      if (!found && free[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // Buffer flags, data registers and the last-loaded pointer. A load has priority over a drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full    <= '0;
      pre_bin <= '1;
      for (int i = 0; i < CH_NUM; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (load && sel == BIN_WIDTH'(i)) begin
          data_q[i] <= s_data;
          full[i]   <= 1'b1;
        end else if (full[i] && m_ready[i]) begin
          full[i] <= 1'b0;
        end
      end
      if (load) pre_bin <= sel;
    end
  end

  genvar g;
  generate
    for (g = 0; g < CH_NUM; g++) begin : g_data
      assign m_data[g*DATA_WIDTH +: DATA_WIDTH] = data_q[g];
    end
  endgenerate

`ifdef LDL_ROUND_DISPATCH_CNT_EN
  logic [15:0] cnt_q [CH_NUM];

  // Per-channel load counters. Each one stops at 0xFFFF instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (load && sel == BIN_WIDTH'(i) && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  generate
    for (g = 0; g < CH_NUM; g++) begin : g_cnt
      assign cnt[g*16 +: 16] = cnt_q[g];
    end
  endgenerate
`else
  assign cnt = '0;
`endif

endmodule

// File: tb/tb_ldl_round_dispatch.sv
// Directed testbench for ldl_round_dispatch with BIN_WIDTH=2, CH_NUM=4, DATA_WIDTH=8.
// The inputs are driven 1 ns after each rising edge.
// The outputs are checked before the next rising edge.
module tb_ldl_round_dispatch;

  localparam int BW = 2;
  localparam int CN = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rst_n;
  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   s_data;
  logic [CN-1:0]   m_valid;
  logic [CN-1:0]   m_ready;
  logic [CN*DW-1:0] m_data;
  logic [BW-1:0]   pre_bin;
  logic [CN*16-1:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_word;

  ldl_round_dispatch #(.BIN_WIDTH(BW), .CH_NUM(CN), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .pre_bin(pre_bin), .cnt(cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] slice(input int i);
    return m_data[i*DW +: DW];
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    s_data = '0;
    do_reset();
    check("rst_m_valid", 64'(m_valid), 64'h0);
    check("rst_pre_bin", 64'(pre_bin), 64'h3);
    check("rst_m_data", 64'(m_data), 64'h0);
    check("rst_cnt", cnt, 64'h0);
    settle();
    check("rst_s_ready", 64'(s_ready), 64'h1);

    // Round robin with every consumer ready: channels 0,1,2,3,0
    m_ready = 4'hF;
    s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_data = 8'h10 + 8'(k);
      exp_q.push_back(s_data);
      settle();
      check("rr_s_ready", 64'(s_ready), 64'h1);
      tick();
      exp_word = exp_q.pop_front();
      check("rr_pre_bin", 64'(pre_bin), 64'(k % 4));
      check("rr_m_valid", 64'(m_valid), 64'(1 << (k % 4)));
      check("rr_m_data", 64'(slice(k % 4)), 64'(exp_word));
    end
    s_valid = 1'b0;
    tick();
    check("rr_drained", 64'(m_valid), 64'h0);
    check("rr_pre_bin_hold", 64'(pre_bin), 64'h0);

    // Backpressure: 4 words accepted, 5th held until m_ready[2]
    do_reset();
    for (int k = 0; k < 4; k++) push(8'h20 + 8'(k));
    check("bp_m_valid", 64'(m_valid), 64'hF);
    check("bp_m_data", 64'(m_data), 64'h23222120);
    s_valid = 1'b1;
    s_data  = 8'h24;
    settle();
    check("bp_s_ready_low", 64'(s_ready), 64'h0);
    tick();
    check("bp_hold_m_data", 64'(m_data), 64'h23222120);
    check("bp_hold_pre_bin", 64'(pre_bin), 64'h3);
    m_ready = 4'b0100;
    settle();
    check("bp_s_ready_up", 64'(s_ready), 64'h1);
    tick();
    s_valid = 1'b0;
    m_ready = '0;
    check("bp_pre_bin", 64'(pre_bin), 64'h2);
    check("bp_m_data2", 64'(slice(2)), 64'h24);
    check("bp_m_valid2", 64'(m_valid), 64'hF);

    // Wrap-around: pre_bin=1, ch2/ch3 full -> 0xAA goes to ch0
    do_reset();
    for (int k = 0; k < 4; k++) push(8'h30 + 8'(k));
    m_ready = 4'b0011;
    tick();
    m_ready = '0;
    push(8'h34);
    push(8'h35);
    m_ready = 4'b0011;
    tick();
    m_ready = '0;
    check("wr_setup_valid", 64'(m_valid), 64'hC);
    check("wr_setup_pre_bin", 64'(pre_bin), 64'h1);
    push(8'hAA);
    check("wr_pre_bin", 64'(pre_bin), 64'h0);
    check("wr_m_valid", 64'(m_valid), 64'hD);
    check("wr_m_data0", 64'(slice(0)), 64'hAA);
    check("wr_m_data2", 64'(slice(2)), 64'h32);

    // Same-cycle drain and load of ch1, which is selected as the last candidate (pre_bin)
    push(8'h44);
    check("dl_pre_bin_setup", 64'(pre_bin), 64'h1);
    m_ready = 4'b0010;
    s_valid = 1'b1;
    s_data  = 8'h55;
    settle();
    check("dl_s_ready", 64'(s_ready), 64'h1);
    check("dl_old_word", 64'(slice(1)), 64'h44);
    tick();
    s_valid = 1'b0;
    m_ready = '0;
    check("dl_m_valid", 64'(m_valid), 64'hF);
    check("dl_m_data1", 64'(slice(1)), 64'h55);
    check("dl_pre_bin", 64'(pre_bin), 64'h1);

    // Reset mid-stream with 3 buffers full. A word offered during reset is dropped.
    m_ready = 4'b1000;
    tick();
    m_ready = '0;
    check("mr_three_full", 64'(m_valid), 64'h7);
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h66;
    tick();
    check("mr_m_valid", 64'(m_valid), 64'h0);
    check("mr_pre_bin", 64'(pre_bin), 64'h3);
    check("mr_m_data0", 64'(slice(0)), 64'h0);
    rst_n  = 1'b1;
    s_data = 8'h77;
    tick();
    s_valid = 1'b0;
    check("mr_next_m_valid", 64'(m_valid), 64'h1);
    check("mr_next_m_data", 64'(slice(0)), 64'h77);
    check("mr_next_pre_bin", 64'(pre_bin), 64'h0);

    // Loads forced to ch0: fill all four buffers, then keep only ch0 draining
    do_reset();
    for (int k = 0; k < 4; k++) push(8'h80 + 8'(k));
    m_ready = 4'b0001;
    s_valid = 1'b1;
    s_data  = 8'h99;
    for (int k = 0; k < 10; k++) tick();
    check("cnt_ch0_pre_bin", 64'(pre_bin), 64'h0);
`ifdef LDL_ROUND_DISPATCH_CNT_EN
    check("cnt_ch0_11", 64'(cnt[15:0]), 64'd11);
    check("cnt_ch1_1", 64'(cnt[31:16]), 64'd1);
    for (int k = 0; k < 70000; k++) tick();
    check("cnt_ch0_sat", 64'(cnt[15:0]), 64'hFFFF);
    check("cnt_ch3_1", 64'(cnt[63:48]), 64'd1);
`else
    check("cnt_zero", cnt, 64'h0);
`endif
    s_valid = 1'b0;
    m_ready = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
